// File: rtl/accum_controller_pkg.sv
// Shared widths and FSM state encoding for the accumulator sequencer.
package accum_controller_pkg;

  localparam int unsigned AccW = 16;
  localparam int unsigned OpW  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/accum_controller_adder.sv
// Zero-extending 8+16-bit adder; produces no carry-out of its own.
module accum_controller_adder
  import accum_controller_pkg::*;
(
  input  logic [OpW-1:0]  i_new_operand,
  input  logic [AccW-1:0] i_current_value,
  output logic [AccW-1:0] o_sum
);

  logic [AccW-1:0] w_operand_ext;

  assign w_operand_ext = {{(AccW - OpW){1'b0}}, i_new_operand};
  assign o_sum         = i_current_value + w_operand_ext;

endmodule

// File: rtl/accum_controller.sv
// Burst sequencer: accepts COUNT operands over valid/ready and sums them into a 16-bit register.
module accum_controller
  import accum_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic                 abort,
  input  logic [OpW-1:0]       operand,
  input  logic                 operand_valid,
  output logic                 operand_ready,
  output logic                 busy,
  output logic                 done,
  output logic [AccW-1:0]      result,
  output logic                 overflow
);

  state_e               r_state, w_state_next;
  logic [AccW-1:0]      r_acc, w_acc_next, w_sum;
  logic [CNT_WIDTH-1:0] r_remaining, w_remaining_next;
  logic                 r_overflow, w_overflow_next;
  logic                 w_carry;

  accum_controller_adder u_adder (
    .i_new_operand  (operand),
    .i_current_value(r_acc),
    .o_sum          (w_sum)
  );

  // The adder has no carry-out, so an unsigned wrap is the carry.
  assign w_carry = (w_sum < r_acc);

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_remaining_next = r_remaining;
    w_overflow_next  = r_overflow;
    operand_ready    = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;

    case (r_state)
      StIdle: begin
        if (start) begin
          w_acc_next      = '0;
          w_overflow_next = 1'b0;
          if (count != '0) begin
            w_remaining_next = count;
            w_state_next     = StAccum;
          end else begin
            w_state_next = StDone;
          end
        end
      end
      StAccum: begin
        operand_ready = 1'b1;
        busy          = 1'b1;
        // Abort outranks a simultaneous valid operand, which is left unconsumed.
        if (abort) begin
          w_state_next = StIdle;
        end else if (operand_valid) begin
          w_acc_next       = (SATURATE && w_carry) ? '1 : w_sum;
          w_overflow_next  = r_overflow | w_carry;
          w_remaining_next = r_remaining - CNT_WIDTH'(1);
          if (r_remaining == CNT_WIDTH'(1)) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_remaining <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_remaining <= w_remaining_next;
      r_overflow  <= w_overflow_next;
    end
  end

  assign result   = r_acc;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_accum_controller.sv
// Bench for accum_controller: three builds (8-bit wrap, 9-bit wrap, 9-bit saturate) in lockstep.
module tb_accum_controller;

  logic        clk = 1'b0;
  logic        reset, start, abort, valid;
  logic [8:0]  count9;
  logic [7:0]  operand;
  logic [2:0]  rdy, bsy, dn, ovf;
  logic [15:0] res [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ops_q[$];

  always #5 clk = ~clk;

  accum_controller #(.CNT_WIDTH(8), .SATURATE(1'b0)) u_dut8w (
    .clk(clk), .reset(reset), .start(start), .count(count9[7:0]), .abort(abort),
    .operand(operand), .operand_valid(valid), .operand_ready(rdy[0]), .busy(bsy[0]),
    .done(dn[0]), .result(res[0]), .overflow(ovf[0])
  );

  accum_controller #(.CNT_WIDTH(9), .SATURATE(1'b0)) u_dut9w (
    .clk(clk), .reset(reset), .start(start), .count(count9), .abort(abort),
    .operand(operand), .operand_valid(valid), .operand_ready(rdy[1]), .busy(bsy[1]),
    .done(dn[1]), .result(res[1]), .overflow(ovf[1])
  );

  accum_controller #(.CNT_WIDTH(9), .SATURATE(1'b1)) u_dut9s (
    .clk(clk), .reset(reset), .start(start), .count(count9), .abort(abort),
    .operand(operand), .operand_valid(valid), .operand_ready(rdy[2]), .busy(bsy[2]),
    .done(dn[2]), .result(res[2]), .overflow(ovf[2])
  );

  typedef struct {
    int          cnt;
    logic [7:0]  base;
    logic [7:0]  step;
    int          gap;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control triple {ready, done, busy} on every selected DUT.
  task automatic chk_ctl(input string nm, input logic [2:0] m, input logic [2:0] exp);
    for (int d = 0; d < 3; d++)
      if (m[d]) chk($sformatf("%s d%0d rdy/done/busy", nm, d), {rdy[d], dn[d], bsy[d]}, exp);
  endtask

  task automatic chk_out(input string nm, input logic [2:0] m, input logic [15:0] ew,
                         input logic [15:0] es, input bit eo);
    for (int d = 0; d < 3; d++) begin
      if (m[d]) begin
        chk($sformatf("%s d%0d result", nm, d), res[d], (d == 2) ? es : ew);
        chk($sformatf("%s d%0d overflow", nm, d), ovf[d], eo);
      end
    end
  endtask

  // Reference: the burst result depends only on the arithmetic total of its operands.
  function automatic void model(output logic [15:0] ew, output logic [15:0] es, output bit eo);
    int unsigned tot = 0;
    foreach (ops_q[i]) tot += ops_q[i];
    eo = (tot > 32'd65535);
    ew = 16'(tot);
    es = eo ? 16'hFFFF : 16'(tot);
  endfunction

  task automatic burst(input string nm, input int cnt, input int gap, input bit rnd_gap,
                       input logic [15:0] ew, input logic [15:0] es, input bit eo);
    logic [2:0] m;
    int g;
    m      = (cnt < 256) ? 3'b111 : 3'b110;
    count9 = 9'(cnt);
    start  = 1'b1;
    valid  = 1'b0;
    tick();
    start = 1'b0;
    for (int idx = 0; idx < cnt; idx++) begin
      g = 0;
      if (idx > 0) g = rnd_gap ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0) : gap;
      chk_ctl({nm, " accum"}, m, 3'b101);
      repeat (g) begin
        valid   = 1'b0;
        operand = 8'($urandom);
        tick();
        chk_ctl({nm, " gap"}, m, 3'b101);
      end
      valid   = 1'b1;
      operand = ops_q[idx];
      tick();
      valid = 1'b0;
    end
    chk_ctl({nm, " done"}, m, 3'b011);
    chk_out({nm, " final"}, m, ew, es, eo);
    valid   = 1'b1;
    operand = 8'h5A;
    tick();
    valid = 1'b0;
    chk_ctl({nm, " after"}, m, 3'b000);
    chk_out({nm, " hold"}, m, ew, es, eo);
  endtask

  initial begin
    logic [15:0] ew, es;
    bit          eo;
    int          cnt;

    tbl[0] = '{3,   8'h10, 8'h10, 0, 16'h0060, 16'h0060, 1'b0};
    tbl[1] = '{2,   8'hFF, 8'h02, 3, 16'h0100, 16'h0100, 1'b0};
    tbl[2] = '{255, 8'hFF, 8'h00, 0, 16'hFE01, 16'hFE01, 1'b0};
    tbl[3] = '{2,   8'hFF, 8'h00, 0, 16'h01FE, 16'h01FE, 1'b0};
    tbl[4] = '{0,   8'h00, 8'h00, 0, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{257, 8'hFF, 8'h00, 0, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[6] = '{258, 8'hFF, 8'h00, 0, 16'h00FE, 16'hFFFF, 1'b1};
    tbl[7] = '{511, 8'hFF, 8'h00, 0, 16'hFD01, 16'hFFFF, 1'b1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; count9 = '0; operand = '0;
    repeat (2) tick();
    chk_ctl("reset", 3'b111, 3'b000);
    chk_out("reset", 3'b111, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      ops_q.delete();
      for (int k = 0; k < tbl[i].cnt; k++) ops_q.push_back(8'(tbl[i].base + 8'(k) * tbl[i].step));
      burst($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].gap, 1'b0,
            tbl[i].exp_wrap, tbl[i].exp_sat, tbl[i].exp_ovf);
    end

    // Reset mid-burst after two operands.
    count9 = 9'd5; start = 1'b1; tick(); start = 1'b0;
    valid = 1'b1; operand = 8'h03; tick();
    operand = 8'h04; tick();
    reset = 1'b1; tick();
    reset = 1'b0; valid = 1'b0;
    chk_ctl("midreset", 3'b111, 3'b000);
    chk_out("midreset", 3'b111, 16'h0, 16'h0, 1'b0);

    // Abort with valid after one operand; a start in ACCUM must not restart.
    count9 = 9'd4; start = 1'b1; tick(); start = 1'b0;
    valid = 1'b1; operand = 8'h05; tick();
    valid = 1'b0; start = 1'b1; count9 = 9'd1; tick();
    start = 1'b0;
    chk_ctl("start_in_accum", 3'b111, 3'b101);
    chk_out("start_in_accum", 3'b111, 16'h0005, 16'h0005, 1'b0);
    abort = 1'b1; valid = 1'b1; operand = 8'h77; tick();
    abort = 1'b0; valid = 1'b0;
    chk_ctl("abort", 3'b111, 3'b000);
    chk_out("abort", 3'b111, 16'h0005, 16'h0005, 1'b0);
    tick();
    chk_ctl("abort_nodone", 3'b111, 3'b000);
    chk_out("abort_hold", 3'b111, 16'h0005, 16'h0005, 1'b0);

    // Randomized bursts against the arithmetic model.
    for (int r = 0; r < 16; r++) begin
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(256, 400))
                                        : int'($urandom_range(0, 40));
      ops_q.delete();
      for (int k = 0; k < cnt; k++)
        ops_q.push_back((cnt > 255) ? 8'($urandom_range(150, 255)) : 8'($urandom));
      model(ew, es, eo);
      burst($sformatf("rnd%0d", r), cnt, 0, 1'b1, ew, es, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
